pcs25g_link_ctrl: RTL and testbench

//  Link bring-up sequencer for the 25G PCS + RS-FEC receive path. Sequences per-lane

---
 rtl/pcs25g_link_ctrl.sv | 139 +++++++++++++
 tb/tb_pcs25g_link_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pcs25g_link_ctrl.sv
// Link bring-up sequencer for the 25G PCS + RS-FEC receive path: block lock, polarity
// correction, AM lock, deskew and FEC alignment, then link_up. All outputs registered.
module pcs25g_link_ctrl #(
  parameter int LANES        = 4,
  parameter int TIMER_W      = 16,
  parameter int LOCK_TIMEOUT = 4095,
  parameter int MAX_RETRY    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             infer_polar,
  input  logic [LANES-1:0] given_polar,
  input  logic             infer_blocklock,
  input  logic [LANES-1:0] given_blocklock,
  input  logic [LANES-1:0] block_lock,
  input  logic             am_lock,
  input  logic             deskew_done,
  input  logic             bypass_fec,
  input  logic             fec_align,
  output logic [LANES-1:0] polar_inv,
  output logic             lane_rst,
  output logic [2:0]       state,
  output logic             link_up,
  output logic [1:0]       retry_cnt,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    RST_LANES   = 3'd1,
    WAIT_BLOCK  = 3'd2,
    FLIP_POLAR  = 3'd3,
    WAIT_AM     = 3'd4,
    WAIT_DESKEW = 3'd5,
    WAIT_FEC    = 3'd6,
    LINK_UP     = 3'd7
  } state_t;

  localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(LOCK_TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_MAX   = '1;
  localparam logic [1:0]         RETRY_MAX   = 2'(MAX_RETRY);

  state_t             cur_state;
  state_t             nxt_state;
  logic [TIMER_W-1:0] timer;
  logic [LANES-1:0]   eff_lock;
  logic               all_lock;
  logic               timed_out;
  logic               retry_inc;

  assign state     = cur_state;
  assign eff_lock  = infer_blocklock ? block_lock : given_blocklock;
  assign all_lock  = &eff_lock;
  assign timed_out = (timer == TIMEOUT_VAL);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    nxt_state = cur_state;
    retry_inc = 1'b0;
    if (!enable) begin
      nxt_state = IDLE;
    end else begin
      unique case (cur_state)
        IDLE:       nxt_state = RST_LANES;
        RST_LANES:  nxt_state = WAIT_BLOCK;
        WAIT_BLOCK: begin
          if (all_lock) begin
            nxt_state = WAIT_AM;
          end else if (timed_out) begin
            nxt_state = infer_polar ? FLIP_POLAR : RST_LANES;
            retry_inc = 1'b1;
          end
        end
        FLIP_POLAR: nxt_state = RST_LANES;
        WAIT_AM: begin
          if (!all_lock) begin
            nxt_state = RST_LANES;
          end else if (am_lock) begin
            nxt_state = WAIT_DESKEW;
          end else if (timed_out) begin
            nxt_state = RST_LANES;
            retry_inc = 1'b1;
          end
        end
        WAIT_DESKEW: begin
          if (!all_lock || !am_lock)  nxt_state = RST_LANES;
          else if (deskew_done)       nxt_state = bypass_fec ? LINK_UP : WAIT_FEC;
        end
        WAIT_FEC: begin
          if (!all_lock || !am_lock)  nxt_state = RST_LANES;
          else if (fec_align)         nxt_state = LINK_UP;
        end
        LINK_UP: begin
          if (!all_lock || !am_lock || !deskew_done || (!fec_align && !bypass_fec))
            nxt_state = RST_LANES;
        end
        default:    nxt_state = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state   <= IDLE;
      timer       <= '0;
      polar_inv   <= '0;
      lane_rst    <= 1'b0;
      link_up     <= 1'b0;
      retry_cnt   <= 2'd0;
      timeout_err <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (nxt_state != cur_state)  timer <= '0;
      else if (timer != TIMER_MAX) timer <= timer + 1'b1;

      lane_rst <= (nxt_state == RST_LANES);
      link_up  <= (nxt_state == LINK_UP);

      // Locked lanes keep their polarity; only lanes still unlocked are inverted.
      if (cur_state == IDLE && nxt_state == RST_LANES)
        polar_inv <= given_polar;
      else if (cur_state == FLIP_POLAR && nxt_state == RST_LANES)
        polar_inv <= polar_inv ^ ~eff_lock;

      if (nxt_state == IDLE) begin
        retry_cnt   <= 2'd0;
        timeout_err <= 1'b0;
      end else if (nxt_state == LINK_UP) begin
        retry_cnt   <= 2'd0;
      end else if (retry_inc) begin
        if (retry_cnt != RETRY_MAX)            retry_cnt   <= retry_cnt + 2'd1;
        if (retry_cnt >= RETRY_MAX - 2'd1)     timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pcs25g_link_ctrl.sv
// Directed bench for pcs25g_link_ctrl: bring-up, polarity flip, retry saturation,
// loss of lock, FEC bypass / forced block lock, enable drop and async reset.
module tb_pcs25g_link_ctrl;

  localparam int LANES = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             infer_polar;
  logic [LANES-1:0] given_polar;
  logic             infer_blocklock;
  logic [LANES-1:0] given_blocklock;
  logic [LANES-1:0] block_lock;
  logic             am_lock;
  logic             deskew_done;
  logic             bypass_fec;
  logic             fec_align;
  logic [LANES-1:0] polar_inv;
  logic             lane_rst;
  logic [2:0]       state;
  logic             link_up;
  logic [1:0]       retry_cnt;
  logic             timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  pcs25g_link_ctrl #(
    .LANES(LANES), .TIMER_W(16), .LOCK_TIMEOUT(100), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .infer_polar(infer_polar),
    .given_polar(given_polar), .infer_blocklock(infer_blocklock),
    .given_blocklock(given_blocklock), .block_lock(block_lock), .am_lock(am_lock),
    .deskew_done(deskew_done), .bypass_fec(bypass_fec), .fec_align(fec_align),
    .polar_inv(polar_inv), .lane_rst(lane_rst), .state(state), .link_up(link_up),
    .retry_cnt(retry_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are stable 1 time unit later.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic lr,
                            input logic lu, input logic [1:0] rc, input logic te,
                            input logic [3:0] pi);
    check({tag, ".state"},       32'(state),       32'(st));
    check({tag, ".lane_rst"},    32'(lane_rst),    32'(lr));
    check({tag, ".link_up"},     32'(link_up),     32'(lu));
    check({tag, ".retry_cnt"},   32'(retry_cnt),   32'(rc));
    check({tag, ".timeout_err"}, 32'(timeout_err), 32'(te));
    check({tag, ".polar_inv"},   32'(polar_inv),   32'(pi));
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; infer_polar = 1'b1; given_polar = 4'h0;
    infer_blocklock = 1'b1; given_blocklock = 4'h0; block_lock = 4'h0;
    am_lock = 1'b1; deskew_done = 1'b1; bypass_fec = 1'b0; fec_align = 1'b1;
    #12;
    check_outs("reset", 3'd0, 0, 0, 2'd0, 0, 4'h0);
    rst_n = 1'b1;
    step();
    check_outs("idle_hold", 3'd0, 0, 0, 2'd0, 0, 4'h0);

    // 1: straight bring-up, block lock after 10 cycles in WAIT_BLOCK
    enable = 1'b1;
    step(); check_outs("t1_rst", 3'd1, 1, 0, 2'd0, 0, 4'h0);
    step(); check_outs("t1_wblk", 3'd2, 0, 0, 2'd0, 0, 4'h0);
    step(9); check("t1_wblk_hold", 32'(state), 32'd2);
    block_lock = 4'hF;
    step(); check("t1_am", 32'(state), 32'd4);
    step(); check("t1_desk", 32'(state), 32'd5);
    step(); check("t1_fec", 32'(state), 32'd6);
    step(); check_outs("t1_up", 3'd7, 0, 1, 2'd0, 0, 4'h0);

    // 4: one-cycle loss of lane 1 in LINK_UP, then relock
    block_lock = 4'hD;
    step(); check_outs("t4_loss", 3'd1, 1, 0, 2'd0, 0, 4'h0);
    block_lock = 4'hF;
    step(); check("t4_wblk", 32'(state), 32'd2);
    step(); check("t4_am", 32'(state), 32'd4);
    step(3); check_outs("t4_up", 3'd7, 0, 1, 2'd0, 0, 4'h0);

    // 2: lane 2 only locks after polarity inversion
    enable = 1'b0;
    step(); check_outs("t2_idle", 3'd0, 0, 0, 2'd0, 0, 4'h0);
    enable = 1'b1; block_lock = 4'hB;
    step(); check("t2_rst", 32'(state), 32'd1);
    step(); check("t2_wblk", 32'(state), 32'd2);
    step(100); check_outs("t2_wblk_last", 3'd2, 0, 0, 2'd0, 0, 4'h0);
    step(); check_outs("t2_flip", 3'd3, 0, 0, 2'd1, 0, 4'h0);
    step(); check_outs("t2_rst2", 3'd1, 1, 0, 2'd1, 0, 4'h4);
    block_lock = 4'hF;
    step(); check("t2_wblk2", 32'(state), 32'd2);
    step(4); check_outs("t2_up", 3'd7, 0, 1, 2'd0, 0, 4'h4);

    // 3: no polarity inference, lane 3 never locks -> retries saturate
    enable = 1'b0;
    step(); check("t3_idle_pol_held", 32'(polar_inv), 32'h4);
    infer_polar = 1'b0; given_polar = 4'h9; block_lock = 4'h7; enable = 1'b1;
    step(); check_outs("t3_rst", 3'd1, 1, 0, 2'd0, 0, 4'h9);
    step();
    for (int k = 1; k <= 4; k++) begin
      step(100); check("t3_wblk_hold", 32'(state), 32'd2);
      step(); check_outs($sformatf("t3_retry%0d", k), 3'd1, 1, 0,
                         2'((k > 3) ? 3 : k), (k >= 3), 4'h9);
      step(); check("t3_wblk_again", 32'(state), 32'd2);
    end

    // 5: FEC bypass and forced block lock
    enable = 1'b0;
    step(); check_outs("t5_idle_clear", 3'd0, 0, 0, 2'd0, 0, 4'h9);
    infer_blocklock = 1'b0; given_blocklock = 4'hF; block_lock = 4'h0;
    bypass_fec = 1'b1; fec_align = 1'b0; given_polar = 4'h5; enable = 1'b1;
    step(); check("t5_rst", 32'(state), 32'd1);
    step(); check("t5_wblk", 32'(state), 32'd2);
    step(); check("t5_am", 32'(state), 32'd4);
    step(); check("t5_desk", 32'(state), 32'd5);
    step(); check_outs("t5_up", 3'd7, 0, 1, 2'd0, 0, 4'h5);

    // 6a: enable drop while stuck in WAIT_AM
    enable = 1'b0;
    step(); check("t6_idle0", 32'(state), 32'd0);
    am_lock = 1'b0; enable = 1'b1;
    step(3); check("t6_am", 32'(state), 32'd4);
    step(); check("t6_am_hold", 32'(state), 32'd4);
    enable = 1'b0;
    step(); check_outs("t6_drop", 3'd0, 0, 0, 2'd0, 0, 4'h5);

    // 6b: asynchronous reset pulse in LINK_UP
    am_lock = 1'b1; enable = 1'b1;
    step(5); check_outs("t6_up", 3'd7, 0, 1, 2'd0, 0, 4'h5);
    #2 rst_n = 1'b0;
    #1 check_outs("t6_async_rst", 3'd0, 0, 0, 2'd0, 0, 4'h0);
    enable = 1'b0;
    #1 rst_n = 1'b1;
    step(); check_outs("t6_after_rst", 3'd0, 0, 0, 2'd0, 0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
